// File: rtl/fizzbuzz_pkg.sv
// Shared fizzbuzz definitions: the token kind carried on the producer/checker
// interface, the checker state encoding, and the kind-selection rule.
// Ports: none (package).
package fizzbuzz_pkg;

  // Token kind on the producer -> checker interface.
  typedef enum logic [1:0] {
    NUM      = 2'd0,
    FIZZ     = 2'd1,
    BUZZ     = 2'd2,
    FIZZBUZZ = 2'd3
  } kind_e;

  // Checker run state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Kind that index n must carry, given whether n is a multiple of 3 / 5.
  function automatic kind_e expected_kind(input logic div3, input logic div5);
    kind_e k;
    k = NUM;
    if (div3 && div5) k = FIZZBUZZ;
    else if (div3)    k = FIZZ;
    else if (div5)    k = BUZZ;
    return k;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD residue counter: holds n mod MOD for a running index n.
// Ports: clk, rst_n (async active-low); init loads 1 (residue of index 1);
//        advance steps the residue by one, wrapping MOD-1 -> 0; value = residue.
module mod_counter #(
  parameter int MOD = 3,
  localparam int W  = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init,
  input  logic         advance,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q, value_d;

  // init has priority so a restart always lands on index 1.
  always_comb begin
    value_d = value_q;
    if (init) begin
      value_d = W'(1);
    end else if (advance) begin
      value_d = (value_q == W'(MOD - 1)) ? '0 : value_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= W'(1);
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/fizzbuzz_checker.sv
// Fizzbuzz stream checker: compares each accepted token against the reference
// sequence for indices 1..MAX, counts mismatches and latches the first one.
// Ports: clk, rst_n (async active-low); start begins a run from IDLE/DONE;
//        in_valid/in_ready/in_kind/in_value token handshake (in_ready depends
//        on state only); busy/done status; err_count (saturating), first_err.
module fizzbuzz_checker
  import fizzbuzz_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MAX   = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_kind,
  input  logic [WIDTH-1:0] in_value,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] err_count,
  output logic [WIDTH-1:0] first_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] err_q, err_d;
  logic [WIDTH-1:0] first_q, first_d;

  logic [1:0] m3;
  logic [2:0] m5;

  logic  accept;
  logic  at_last;
  logic  init_run;
  logic  mismatch;
  kind_e exp_kind;

  assign accept   = in_valid && (state_q == RUN);
  assign at_last  = (n_q == WIDTH'(MAX));
  // start only matters outside RUN, which also covers a start coinciding
  // with the last token.
  assign init_run = start && (state_q != RUN);

  // Residues are held once the last index is reached.
  mod_counter #(.MOD(3)) u_mod3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (init_run),
    .advance (accept && !at_last),
    .value   (m3)
  );

  mod_counter #(.MOD(5)) u_mod5 (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (init_run),
    .advance (accept && !at_last),
    .value   (m5)
  );

  assign exp_kind = expected_kind(m3 == 2'd0, m5 == 3'd0);
  // in_value is only meaningful for NUM tokens.
  assign mismatch = (in_kind != exp_kind) ||
                    ((exp_kind == NUM) && (in_value != n_q));

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    err_d   = err_q;
    first_d = first_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          n_d     = WIDTH'(1);
          err_d   = '0;
          first_d = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (mismatch) begin
            err_d = (err_q == '1) ? err_q : err_q + WIDTH'(1);
            if (first_q == '0) first_d = n_q;
          end
          if (at_last) state_d = DONE;
          else         n_d     = n_q + WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= WIDTH'(1);
      err_q   <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign in_ready  = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign err_count = err_q;
  assign first_err = first_q;

endmodule

// File: tb/tb_fizzbuzz_checker.sv
module tb_fizzbuzz_checker;

  localparam int MAXN [3] = '{15, 100, 15};
  localparam int WID  [3] = '{8, 8, 4};

  logic clk;
  logic rst_n;

  logic       start_s [3];
  logic       valid_s [3];
  logic [1:0] kind_s  [3];
  logic [7:0] value_s [3];

  logic       ready_s [3];
  logic       busy_s  [3];
  logic       done_s  [3];
  logic [7:0] err_s   [3];
  logic [7:0] first_s [3];

  logic       rdy0, rdy1, rdy2, bsy0, bsy1, bsy2, dn0, dn1, dn2;
  logic [7:0] err0, err1, first0, first1;
  logic [3:0] err2, first2;

  assign ready_s[0] = rdy0;  assign ready_s[1] = rdy1;  assign ready_s[2] = rdy2;
  assign busy_s[0]  = bsy0;  assign busy_s[1]  = bsy1;  assign busy_s[2]  = bsy2;
  assign done_s[0]  = dn0;   assign done_s[1]  = dn1;   assign done_s[2]  = dn2;
  assign err_s[0]   = err0;  assign err_s[1]   = err1;  assign err_s[2]   = {4'd0, err2};
  assign first_s[0] = first0; assign first_s[1] = first1; assign first_s[2] = {4'd0, first2};

  fizzbuzz_checker #(.WIDTH(8), .MAX(15)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .in_valid(valid_s[0]),
    .in_ready(rdy0), .in_kind(kind_s[0]), .in_value(value_s[0]),
    .busy(bsy0), .done(dn0), .err_count(err0), .first_err(first0));

  fizzbuzz_checker #(.WIDTH(8), .MAX(100)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .in_valid(valid_s[1]),
    .in_ready(rdy1), .in_kind(kind_s[1]), .in_value(value_s[1]),
    .busy(bsy1), .done(dn1), .err_count(err1), .first_err(first1));

  fizzbuzz_checker #(.WIDTH(4), .MAX(15)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .in_valid(valid_s[2]),
    .in_ready(rdy2), .in_kind(kind_s[2]), .in_value(value_s[2][3:0]),
    .busy(bsy2), .done(dn2), .err_count(err2), .first_err(first2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] value;
    logic [7:0] exp_err;
    logic [7:0] exp_first;
  } vec_t;

  vec_t tbl [100];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference kind for index i, straight from the fizzbuzz rule.
  function automatic logic [1:0] ref_kind(input int i);
    if (i % 15 == 0) return 2'd3;
    if (i % 3 == 0)  return 2'd1;
    if (i % 5 == 0)  return 2'd2;
    return 2'd0;
  endfunction

  // mode: 0 clean, 1 corrupt 6 and 7, 2 every token wrong, 3 corrupt 3,
  // 4 random corruption (~20%).
  task automatic fill_table(input int d, input int mode);
    int err, first, sat, v;
    logic [1:0] k;
    logic bad;
    err = 0; first = 0; sat = (1 << WID[d]) - 1;
    for (int i = 1; i <= MAXN[d]; i++) begin
      k = ref_kind(i); v = i;
      case (mode)
        1: begin
          if (i == 6) begin k = 2'd0; v = 6; end
          if (i == 7) begin k = 2'd0; v = 8; end
        end
        2: k = k ^ 2'b01;
        3: if (i == 3) begin k = 2'd0; v = 3; end
        4: if ($urandom % 5 == 0) begin
             k = 2'($urandom % 4); v = int'($urandom % 256);
           end
        default: ;
      endcase
      bad = (k != ref_kind(i)) || ((ref_kind(i) == 2'd0) && (v != i));
      if (bad) begin
        if (err < sat) err++;
        if (first == 0) first = i;
      end
      tbl[i-1].kind      = k;
      tbl[i-1].value     = 8'(v);
      tbl[i-1].exp_err   = 8'(err);
      tbl[i-1].exp_first = 8'(first);
    end
  endtask

  // Offer one token and wait (bounded) until it is taken; returns at posedge+1.
  task automatic push(input int d, input logic [1:0] k, input logic [7:0] v);
    bit ok;
    ok = 0;
    valid_s[d] = 1'b1; kind_s[d] = k; value_s[d] = v;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (ready_s[d]) begin ok = 1; break; end
    end
    if (!ok) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    valid_s[d] = 1'b0;
  endtask

  task automatic start_run(input int d);
    @(posedge clk); #1 start_s[d] = 1'b1;
    @(posedge clk); #1 start_s[d] = 1'b0;
    chk("start_busy", busy_s[d], 1);
    chk("start_ready", ready_s[d], 1);
    chk("start_err_clr", err_s[d], 0);
    chk("start_first_clr", first_s[d], 0);
  endtask

  task automatic apply_table(input int d, input bit gaps);
    int hs;
    hs = 0;
    for (int i = 0; i < MAXN[d]; i++) begin
      if (gaps) begin
        for (int g = 0; g < 20 && $urandom_range(0, 1) == 1; g++) begin
          @(negedge clk);
          chk("gap_not_done", done_s[d], 0);
          @(posedge clk); #1;
        end
      end
      push(d, tbl[i].kind, tbl[i].value);
      hs++;
      chk("tok_err", err_s[d], tbl[i].exp_err);
      chk("tok_first", first_s[d], tbl[i].exp_first);
      chk("tok_done", done_s[d], (hs == MAXN[d]) ? 1 : 0);
      chk("tok_busy", busy_s[d], (hs == MAXN[d]) ? 0 : 1);
    end
  endtask

  task automatic chk_reset_vals(input int d);
    chk("rst_ready", ready_s[d], 0);
    chk("rst_busy", busy_s[d], 0);
    chk("rst_done", done_s[d], 0);
    chk("rst_err", err_s[d], 0);
    chk("rst_first", first_s[d], 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 0; valid_s[d] = 0; kind_s[d] = 0; value_s[d] = 0;
    end
    #12;
    for (int d = 0; d < 3; d++) chk_reset_vals(d);
    rst_n = 1'b1;

    // Clean back-to-back run, MAX=15.
    fill_table(0, 0);
    start_run(0);
    apply_table(0, 0);
    chk("clean_final_err", err_s[0], 0);
    chk("clean_final_first", first_s[0], 0);

    // Tokens offered in DONE must be ignored.
    valid_s[0] = 1'b1; kind_s[0] = 2'd3; value_s[0] = 8'd0;
    repeat (3) begin
      @(negedge clk);
      chk("done_no_ready", ready_s[0], 0);
    end
    valid_s[0] = 1'b0;
    chk("done_hold_err", err_s[0], 0);
    chk("done_hold_done", done_s[0], 1);

    // Corrupted indices 6 and 7.
    fill_table(0, 1);
    start_run(0);
    apply_table(0, 0);
    chk("corrupt_err", err_s[0], 2);
    chk("corrupt_first", first_s[0], 6);

    // Clean stream with random gaps, MAX=100.
    fill_table(1, 0);
    start_run(1);
    apply_table(1, 1);
    chk("gap_clean_err", err_s[1], 0);

    // Random corruption with gaps, MAX=100.
    fill_table(1, 4);
    start_run(1);
    apply_table(1, 1);

    // WIDTH=4, every token wrong.
    fill_table(2, 2);
    start_run(2);
    apply_table(2, 0);
    chk("sat_err", err_s[2], 15);
    chk("sat_first", first_s[2], 1);

    // start held through RUN and DONE; index 3 corrupted.
    fill_table(0, 3);
    @(posedge clk); #1 start_s[0] = 1'b1;
    apply_table(0, 0);
    chk("held_done", done_s[0], 1);
    chk("held_err", err_s[0], 1);
    chk("held_first", first_s[0], 3);
    @(posedge clk); #1;
    chk("held_restart_busy", busy_s[0], 1);
    chk("held_restart_err", err_s[0], 0);
    chk("held_restart_first", first_s[0], 0);
    start_s[0] = 1'b0;
    fill_table(0, 0);
    apply_table(0, 0);
    chk("held_clean_err", err_s[0], 0);

    // Reset mid-run at n=7, then a fresh clean run.
    fill_table(0, 1);
    start_run(0);
    for (int i = 0; i < 6; i++) push(0, tbl[i].kind, tbl[i].value);
    rst_n = 1'b0;
    #2;
    chk_reset_vals(0);
    @(posedge clk); @(posedge clk); #3;
    chk_reset_vals(0);
    rst_n = 1'b1;
    fill_table(0, 0);
    start_run(0);
    apply_table(0, 0);
    chk("post_rst_err", err_s[0], 0);
    chk("post_rst_first", first_s[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fizzbuzz_checker.md
# fizzbuzz_checker

Stream checker for the fizzbuzz sanity design: consumes the token stream a fizzbuzz producer emits over a valid/ready interface and checks each token against an internally generated reference sequence for indices 1..MAX. It is the receiving end of the producer's token interface and sits in the sanity testbench top, driving pass/fail status. It counts mismatches, latches the index of the first mismatch and signals completion after MAX tokens.

## Interface
- WIDTH, 8: width of index, value and error counters
- MAX, 100: last index in the sequence; 1 <= MAX <= 2^WIDTH-1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a check run; sampled in IDLE or DONE, ignored in RUN
- in_valid  input  1  producer has a token
- in_ready  output  1  checker accepts the token this cycle
- in_kind  input  2  token kind: NUM=0, FIZZ=1, BUZZ=2, FIZZBUZZ=3
- in_value  input  WIDTH  number carried by a NUM token; ignored for other kinds
- busy  output  1  high in RUN
- done  output  1  high in DONE
- err_count  output  WIDTH  mismatches in the current run, saturating at 2^WIDTH-1
- first_err  output  WIDTH  index of the first mismatch; 0 means no mismatch

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE -> RUN on start. Entering RUN: n=1, m3=1, m5=1, err_count=0, first_err=0.
- RUN: in_ready=1. A token is accepted on a cycle with in_valid & in_ready.
- Expected kind for index n:
  - FIZZBUZZ if m3==0 and m5==0
  - FIZZ if only m3==0
  - BUZZ if only m5==0
  - NUM otherwise
- Mismatch: in_kind differs from the expected kind, or the expected kind is NUM and in_value != n.
- On an accepted mismatch:
  - err_count increments, saturating at all-ones.
  - first_err <= n if first_err==0.
- On an accepted token with n != MAX: n <= n+1; m3 <= (m3==2)?0:m3+1; m5 <= (m5==4)?0:m5+1. No divide or modulo operators.
- On an accepted token with n == MAX: go to DONE. Counters hold; err_count and first_err include this token's result.
- DONE: in_ready=0, done=1, results held. start re-enters RUN with the initialisation above.
- in_valid low in RUN: nothing advances, no timeout.
- IDLE and DONE: tokens are not accepted (in_ready=0) and in_valid is ignored.

## Timing
- Reset values: in_ready=0, busy=0, done=0, err_count=0, first_err=0. Internal state: IDLE, n=1, m3=1, m5=1.
- Asserting rst_n low at any time, including mid-run, returns the block to reset values immediately. A partial run is discarded.
- start -> busy and in_ready high on the next cycle.
- Throughput: one token per cycle. in_ready is a pure function of state, with no combinational path from in_valid.
- Result latency: err_count and first_err update on the edge that accepts the token and are visible the next cycle.
- Last token (n==MAX): done=1 and busy=0 the cycle after acceptance. No further token is accepted.
- A start on the same edge as the last token is ignored, because the block is still in RUN.

## Structure
- Shared package fizzbuzz_pkg holds:
  - the 2-bit token kind enum typedef (NUM, FIZZ, BUZZ, FIZZBUZZ), shared with the producer;
  - the state enum for this block.
- One sub-module, mod_counter, parameterised by MOD:
  - inputs: init, advance;
  - output: value of width clog2(MOD);
  - init loads 1;
  - instantiated twice, with MOD=3 and MOD=5.

## Test plan
- Clean run, MAX=15, ideal producer streaming back-to-back: NUM 1, 2, FIZZ, 4, BUZZ, ..., FIZZBUZZ at 15 -> done after 15 accepts, err_count=0, first_err=0.
- Corrupt index 6 (send NUM 6 instead of FIZZ) and index 7 (send NUM 8) -> err_count=2, first_err=6.
- Random in_valid gaps (about 50%) on a clean stream, MAX=100 -> err_count=0, done only after exactly 100 handshakes.
- WIDTH=4, MAX=15, every token wrong -> err_count saturates at 15, first_err=1.
- Assert rst_n low mid-run at n=7, then start again -> outputs at reset values during reset, new run begins at index 1, clean result.
- start held high through RUN and DONE -> ignored in RUN, immediate restart from DONE with err_count cleared.
